// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and constants for the DMA copy/fill engine:
//               FSM state encoding, transfer-mode constants, memory depth.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    // Engine states; two bits cover all four.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_t;

    // Transfer mode as sampled from the mode input.
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // Words in the attached data memory; only the low address bits decode.
    localparam int MEM_DEPTH = 1024;

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : dma_addr_gen
// Description : Source/destination pointer and remaining-count registers for
//               the DMA engine. Resolves copy direction once at load (memmove
//               overlap rule) and steps all three registers on each write.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int AW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,      // latch a new transfer
    input  logic          step_i,      // one word written this cycle
    input  logic          mode_i,      // transfer mode at load time
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [LW-1:0] len_i,
    output logic [AW-1:0] src_nxt_o,   // pointer value after this edge
    output logic [AW-1:0] dst_nxt_o,
    output logic          last_o       // current write is the final word
);

    localparam int XW = AW + 1;

    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          desc_q, desc_d;

    logic [XW-1:0] w_src_x;
    logic [XW-1:0] w_dst_x;
    logic [XW-1:0] w_len_x;
    logic [AW-1:0] w_len_a;
    logic          w_overlap;

    // Overlap compare one bit wider than the address so src+len cannot wrap.
    always_comb begin
        w_src_x   = {1'b0, src_i};
        w_dst_x   = {1'b0, dst_i};
        w_len_x   = XW'(len_i);
        w_len_a   = AW'(len_i);
        w_overlap = (mode_i == MODE_COPY) &&
                    (w_dst_x > w_src_x) &&
                    (w_dst_x < (w_src_x + w_len_x));
    end

    // Next-state for pointers, count and direction.
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        rem_d  = rem_q;
        desc_d = desc_q;
        if (load_i) begin
            desc_d = w_overlap;
            rem_d  = len_i;
            if (w_overlap) begin
                // Descending copy starts at the top of each range.
                src_d = src_i + w_len_a - AW'(1);
                dst_d = dst_i + w_len_a - AW'(1);
            end else begin
                src_d = src_i;
                dst_d = dst_i;
            end
        end else if (step_i) begin
            src_d = desc_q ? (src_q - AW'(1)) : (src_q + AW'(1));
            dst_d = desc_q ? (dst_q - AW'(1)) : (dst_q + AW'(1));
            rem_d = rem_q - LW'(1);
        end
    end

    // Working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            desc_q <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            rem_q  <= rem_d;
            desc_q <= desc_d;
        end
    end

    assign src_nxt_o = src_d;
    assign dst_nxt_o = dst_d;
    assign last_o    = (rem_q == LW'(1));

endmodule : dma_addr_gen
`default_nettype wire

// File: rtl/dma_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : dma_copy_engine
// Description : Block-transfer initiator for the single-port data memory.
//               Performs overlap-safe copy (memmove) or constant fill. All
//               memory-side outputs are registered; the write-data register
//               doubles as the copy buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    dma_state_t    state_q;
    logic          mode_q;
    logic [DW-1:0] fill_q;
    logic          busy_q;
    logic          done_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;     // copy buffer in copy mode, fill word in fill

    logic          w_load;
    logic          w_step;
    logic [AW-1:0] w_src_nxt;
    logic [AW-1:0] w_dst_nxt;
    logic          w_last;

    // Load on an accepted start, step on every write cycle.
    always_comb begin
        w_load = (state_q == ST_IDLE) && start;
        w_step = (state_q == ST_WRITE);
    end

    dma_addr_gen #(
        .AW (AW),
        .LW (LW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (w_load),
        .step_i    (w_step),
        .mode_i    (mode),
        .src_i     (src_addr),
        .dst_i     (dst_addr),
        .len_i     (len),
        .src_nxt_o (w_src_nxt),
        .dst_nxt_o (w_dst_nxt),
        .last_o    (w_last)
    );

    // Transfer FSM; memory port values are set up one edge ahead so that
    // every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_COPY;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        fill_q <= fill_val;
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (mode == MODE_FILL) begin
                            state_q <= ST_WRITE;
                            we_q    <= 1'b1;
                            addr_q  <= w_dst_nxt;
                            wdata_q <= fill_val;
                        end else begin
                            state_q <= ST_READ;
                            addr_q  <= w_src_nxt;
                        end
                    end
                end
                ST_READ: begin
                    // Asynchronous read data is valid in the same cycle.
                    state_q <= ST_WRITE;
                    we_q    <= 1'b1;
                    addr_q  <= w_dst_nxt;
                    wdata_q <= mem_rdata;
                end
                ST_WRITE: begin
                    if (w_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                    end else if (mode_q == MODE_FILL) begin
                        addr_q  <= w_dst_nxt;
                        wdata_q <= fill_q;
                    end else begin
                        state_q <= ST_READ;
                        we_q    <= 1'b0;
                        addr_q  <= w_src_nxt;
                        wdata_q <= '0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    we_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule : dma_copy_engine
`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_copy_engine
// Description : Directed self-checking bench for dma_copy_engine with a
//               1024x16 asynchronous-read memory model on the port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic [15:0] fill_val = '0;
    logic        busy;
    logic        done;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] mem [0:1023];

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int nwe;
    logic [31:0] first_wr;

    always #5 clk = ~clk;

    dma_copy_engine #(.AW(16), .DW(16), .LW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_val  (fill_val),
        .busy      (busy),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory model: async read, low 10 address bits decode; the write port
    // is held off while the system is in reset.
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (mem_we && !rst) mem[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one transfer and run to the DONE cycle (left in DONE on return).
    // With inject set, a conflicting fill request is pulsed mid-transfer.
    task automatic run(input logic m, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] l, input logic [15:0] fv, input bit inject);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_val = fv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; nwe = 0; first_wr = 32'hFFFF_FFFF;
        while (!done && lat < 300) begin
            if (mem_we) begin
                if (nwe == 0) first_wr = {16'h0, mem_addr};
                nwe++;
            end
            if (inject && lat == 3) begin
                start = 1'b1; mode = 1'b1; dst_addr = d; len = 16'd2; fill_val = 16'hDEAD;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        chk("done_seen", {31'h0, done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

        // Reset state
        tick(); tick();
        chk("rst_busy",  {31'h0, busy},   32'h0);
        chk("rst_done",  {31'h0, done},   32'h0);
        chk("rst_we",    {31'h0, mem_we}, 32'h0);
        chk("rst_addr",  {16'h0, mem_addr},  32'h0);
        chk("rst_wdata", {16'h0, mem_wdata}, 32'h0);
        rst = 1'b0;
        tick();

        // Forward copy
        for (int i = 0; i < 4; i++) mem[16'h010 + i] = 16'h00A0 + 16'(i);
        run(1'b0, 16'h0010, 16'h0020, 16'd4, 16'h0, 1'b0);
        chk("fwd_latency", lat, 9);
        chk("fwd_writes",  nwe, 4);
        chk("fwd_first",   first_wr, 32'h20);
        chk("fwd_busy_in_done", {31'h0, busy}, 32'h1);
        tick();
        chk("fwd_busy_after", {31'h0, busy}, 32'h0);
        chk("fwd_done_after", {31'h0, done}, 32'h0);
        for (int i = 0; i < 4; i++)
            chk("fwd_word", {16'h0, mem[16'h020 + i]}, 32'h00A0 + i);

        // Fill
        mem[16'h103] = 16'h5555;
        run(1'b1, 16'h0, 16'h0100, 16'd3, 16'hBEEF, 1'b0);
        chk("fill_latency", lat, 4);
        chk("fill_writes",  nwe, 3);
        tick();
        for (int i = 0; i < 3; i++)
            chk("fill_word", {16'h0, mem[16'h100 + i]}, 32'hBEEF);
        chk("fill_beyond", {16'h0, mem[16'h103]}, 32'h5555);

        // Overlapping copy (descending)
        for (int i = 0; i < 5; i++) mem[i] = 16'(i + 1);
        run(1'b0, 16'h0000, 16'h0002, 16'd5, 16'h0, 1'b0);
        chk("ovl_latency", lat, 11);
        chk("ovl_first",   first_wr, 32'h6);
        tick();
        chk("ovl_w0", {16'h0, mem[0]}, 32'd1);
        chk("ovl_w1", {16'h0, mem[1]}, 32'd2);
        chk("ovl_w2", {16'h0, mem[2]}, 32'd1);
        chk("ovl_w3", {16'h0, mem[3]}, 32'd2);
        chk("ovl_w4", {16'h0, mem[4]}, 32'd3);
        chk("ovl_w5", {16'h0, mem[5]}, 32'd4);
        chk("ovl_w6", {16'h0, mem[6]}, 32'd5);

        // Zero length, then a start pulsed in the DONE cycle
        run(1'b0, 16'h0010, 16'h0300, 16'd0, 16'h0, 1'b0);
        chk("zero_latency", lat, 1);
        chk("zero_writes",  nwe, 0);
        chk("zero_we_in_done", {31'h0, mem_we}, 32'h0);
        start = 1'b1; mode = 1'b1; dst_addr = 16'h0300; len = 16'd1; fill_val = 16'h7777;
        tick();
        start = 1'b0;
        chk("done_start_busy", {31'h0, busy}, 32'h0);
        tick(); tick(); tick();
        chk("done_start_mem", {16'h0, mem[16'h300]}, 32'h0);

        // Start while busy is ignored
        run(1'b0, 16'h0010, 16'h0040, 16'd4, 16'h0, 1'b1);
        chk("busy_start_latency", lat, 9);
        tick();
        for (int i = 0; i < 4; i++)
            chk("busy_start_word", {16'h0, mem[16'h040 + i]}, 32'h00A0 + i);

        // Reset during the third write of an 8-word copy
        for (int i = 0; i < 8; i++) mem[16'h200 + i] = 16'h0300 + 16'(i);
        mode = 1'b0; src_addr = 16'h0200; dst_addr = 16'h0280; len = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        nwe = 0;
        for (int k = 0; k < 100; k++) begin
            if (mem_we) begin
                nwe++;
                if (nwe == 3) break;
            end
            tick();
        end
        chk("rstmid_reached_w3", nwe, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", {31'h0, busy},   32'h0);
        chk("rstmid_we",   {31'h0, mem_we}, 32'h0);
        chk("rstmid_done", {31'h0, done},   32'h0);
        nwe = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) nwe++;
            tick();
        end
        chk("rstmid_no_done", nwe, 0);
        chk("rstmid_w0", {16'h0, mem[16'h280]}, 32'h0300);
        chk("rstmid_w1", {16'h0, mem[16'h281]}, 32'h0301);
        for (int i = 2; i < 8; i++)
            chk("rstmid_untouched", {16'h0, mem[16'h280 + i]}, 32'h0);

        // Wrap-around fill
        run(1'b1, 16'h0, 16'hFFFE, 16'd3, 16'h1111, 1'b0);
        chk("wrap_latency", lat, 4);
        chk("wrap_first",   first_wr, 32'hFFFE);
        tick();
        chk("wrap_3fe", {16'h0, mem[10'h3FE]}, 32'h1111);
        chk("wrap_3ff", {16'h0, mem[10'h3FF]}, 32'h1111);
        chk("wrap_000", {16'h0, mem[0]},       32'h1111);
        chk("wrap_001", {16'h0, mem[1]},       32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dma_copy_engine
`default_nettype wire
